// File: rtl/deserializer_pkg.sv
// Shared definitions for the deserializer: FSM state encoding and counter width helper.
// Counter width matches the serializer's iCounter port: $clog2(MSG_SIZE)+1.
package deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_FULL   = 2'd3
    } deser_state_e;

    function automatic int unsigned cnt_w(input int unsigned msg_size);
        return $clog2(msg_size) + 1;
    endfunction

endpackage

// File: rtl/deserializer_bit_counter.sv
// Saturating up-counter with synchronous clear and block enable.
// Holds at MAX; never wraps.
module bit_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ena) begin
            if (clear) begin
                count <= '0;
            end else if (inc && (count != MAX_V)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel word assembler feeding the serializer (oData_out / oCounter).
// Optional even-parity check bit after each word when DESER_PARITY_EN is defined.
module deserializer
    import deserializer_pkg::*;
#(
    parameter  int unsigned MSG_SIZE = 64,
    localparam int unsigned CNT_W    = cnt_w(MSG_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                iData_bit,
    input  logic                iData_valid,
    input  logic                iClear,
    output logic [MSG_SIZE-1:0] oData_out,
    output logic [CNT_W-1:0]    oCounter,
    output logic                oFull,
`ifdef DESER_PARITY_EN
    output logic                oParity_err,
`endif
    output logic                oOverrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_SIZE - 1);

    deser_state_e state, state_next;

    logic at_last;
    logic cnt_inc;

    assign at_last = (oCounter == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (iClear) begin
            state_next = ST_IDLE;
        end else if (iData_valid) begin
            case (state)
                ST_IDLE:   state_next = ST_SHIFT;
`ifdef DESER_PARITY_EN
                ST_SHIFT:  if (at_last) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_FULL;
`else
                ST_SHIFT:  if (at_last) state_next = ST_FULL;
`endif
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        oFull = (state == ST_FULL);
    end

    // With parity the last data bit leaves the count at MSG_SIZE-1; the parity bit completes it.
    always_comb begin
        cnt_inc = 1'b0;
        if (!iClear && iData_valid) begin
            case (state)
                ST_IDLE:   cnt_inc = 1'b1;
`ifdef DESER_PARITY_EN
                ST_SHIFT:  cnt_inc = !at_last;
                ST_PARITY: cnt_inc = 1'b1;
`else
                ST_SHIFT:  cnt_inc = 1'b1;
`endif
                default:   cnt_inc = 1'b0;
            endcase
        end
    end

    bit_counter #(
        .WIDTH (CNT_W),
        .MAX   (MSG_SIZE)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (iClear),
        .inc   (cnt_inc),
        .count (oCounter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oData_out <= '0;
        end else if (ena) begin
            if (iClear) begin
                oData_out <= '0;
            end else if (iData_valid && (state == ST_IDLE || state == ST_SHIFT)) begin
                oData_out <= {oData_out[MSG_SIZE-2:0], iData_bit};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oOverrun <= 1'b0;
        end else if (ena) begin
            if (iClear) begin
                oOverrun <= 1'b0;
            end else if (iData_valid && state == ST_FULL) begin
                oOverrun <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oParity_err <= 1'b0;
        end else if (ena) begin
            if (iClear) begin
                oParity_err <= 1'b0;
            end else if (iData_valid && state == ST_PARITY) begin
                oParity_err <= ^{oData_out, iData_bit};
            end
        end
    end
`endif

endmodule
